// File: rtl/gh_report_tx_if.sv
// Byte-stream transmit bus between the report packetiser and its sink.
//   TxData  : current packet byte (master -> slave)
//   TxValid : TxData valid (master -> slave)
//   TxReady : sink accepts the byte when TxValid & TxReady (slave -> master)
interface gh_report_tx_if;
    logic [7:0] TxData;
    logic       TxValid;
    logic       TxReady;

    modport master (output TxData, output TxValid, input TxReady);
    modport slave  (input TxData, input TxValid, output TxReady);
endinterface

// File: rtl/gh_report_tx.sv
// Guitar controller report transmitter: packs {Tilt,Strum,Frets,Whammy} into a
// 4-byte packet (sync, buttons, whammy, xor checksum) whenever the state changes
// or a keepalive interval elapses, and streams it over a valid/ready byte bus.
// Ports:
//   CLK, RST      : clock, asynchronous active-high reset
//   Enable        : permits new packets to start
//   Frets, Strum, Whammy, Tilt : live controller state
//   tx            : byte stream master (TxData, TxValid, TxReady)
//   Busy          : packet in flight
//   PacketCount   : number of fully transmitted packets (wraps)
module gh_report_tx #(
    parameter int unsigned KEEPALIVE_CYCLES = 1000000,
    parameter logic [7:0]  SYNC_BYTE        = 8'hA5
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 Enable,
    input  logic [4:0]           Frets,
    input  logic                 Strum,
    input  logic [7:0]           Whammy,
    input  logic                 Tilt,
    gh_report_tx_if.master       tx,
    output logic                 Busy,
    output logic [15:0]          PacketCount
);

    localparam int unsigned ST_W = 15;
    localparam int unsigned KA_W = (KEEPALIVE_CYCLES > 1) ? $clog2(KEEPALIVE_CYCLES) : 1;
    localparam logic [KA_W-1:0] KA_MAX = KA_W'(KEEPALIVE_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [ST_W-1:0]   snap_q, snap_d;
    logic [KA_W-1:0]   ka_q, ka_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              busy_q, busy_d;

    logic [ST_W-1:0]   cur_state;
    logic              changed;
    logic              expired;

    // Packet byte i built from a snapshot laid out as {Tilt,Strum,Frets,Whammy}.
    function automatic logic [7:0] pkt_byte(input logic [ST_W-1:0] s, input logic [1:0] i);
        logic [7:0] b1;
        b1 = {s[14], s[13], 1'b0, s[12:8]};
        case (i)
            2'd0:    pkt_byte = SYNC_BYTE;
            2'd1:    pkt_byte = b1;
            2'd2:    pkt_byte = s[7:0];
            default: pkt_byte = SYNC_BYTE ^ b1 ^ s[7:0];
        endcase
    endfunction

    assign cur_state = {Tilt, Strum, Frets, Whammy};
    assign changed   = (cur_state != snap_q);
    assign expired   = (ka_q == KA_MAX);

    // State and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            snap_q     <= '0;
            ka_q       <= '0;
            cnt_q      <= 16'd0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            snap_q     <= snap_d;
            ka_q       <= ka_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state logic; outputs are precomputed from the next state so they
    // come straight out of flops.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        ka_d    = ka_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (Enable) begin
                    if (changed || expired) begin
                        state_d = SEND;
                        snap_d  = cur_state;
                        idx_d   = 2'd0;
                        ka_d    = '0;
                    end else if (!expired) begin
                        ka_d = ka_q + KA_W'(1);
                    end
                end else begin
                    ka_d = '0;
                end
            end
            SEND: begin
                ka_d = '0;
                if (tx_valid_q && tx.TxReady) begin
                    if (idx_q == 2'd3) begin
                        state_d = IDLE;
                        idx_d   = 2'd0;
                        cnt_d   = cnt_q + 16'd1;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        tx_valid_d = (state_d == SEND);
        busy_d     = (state_d == SEND);
        tx_data_d  = (state_d == SEND) ? pkt_byte(snap_d, idx_d) : 8'h00;
    end

    assign tx.TxData  = tx_data_q;
    assign tx.TxValid = tx_valid_q;
    assign Busy       = busy_q;
    assign PacketCount = cnt_q;

endmodule
